// File: rtl/t05_char_ingress.sv
// Symbol ingress: level handshake capture FSM feeding a show-ahead FIFO for the histogram stage.
// Optional end-of-text marking and capture blocking are enabled by defining T05_INGRESS_EOF_EN.
module t05_char_ingress #(
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  EOF_CHAR = 8'h1A
) (
  input  logic                      hwclk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      pulse_in,
  input  logic [DATA_W-1:0]         read_out,
  output logic                      spi_confirm_out,
  output logic                      nextChar,
  output logic                      sym_valid,
  output logic [DATA_W-1:0]         sym_data,
  output logic                      sym_last,
  input  logic                      sym_ready,
  output logic                      eof_seen,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               sym_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CONFIRM  = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       sym_cnt_q, sym_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic full, eof_block, push, pop;

  assign full = (count_q == CW'(DEPTH));

`ifdef T05_INGRESS_EOF_EN
  localparam logic [DATA_W-1:0] EOF_SYM = DATA_W'(EOF_CHAR);
  logic             eof_q, eof_d;
  logic [DEPTH-1:0] last_q;
  logic             is_eof;

  assign is_eof    = (read_out == EOF_SYM);
  assign eof_block = eof_q;
  assign eof_seen  = eof_q;
  assign sym_last  = sym_valid & last_q[rd_ptr_q];

  always_comb begin
    eof_d = eof_q;
    if (clear)
      eof_d = 1'b0;
    else if (push && is_eof)
      eof_d = 1'b1;
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) eof_q <= 1'b0;
    else       eof_q <= eof_d;
  end

  // Marker bit travels with the data word; no reset needed since count gates visibility.
  always_ff @(posedge hwclk) begin
    if (push) last_q[wr_ptr_q] <= is_eof;
  end
`else
  assign eof_block = 1'b0;
  assign eof_seen  = 1'b0;
  assign sym_last  = 1'b0;
`endif

  // Capture is level-based and only from IDLE, so a held pulse_in cannot re-capture.
  assign push = (state_q == IDLE) && pulse_in && !full && !eof_block && !clear;
  assign pop  = sym_valid && sym_ready && !clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (push) state_d = CONFIRM;
      CONFIRM:  state_d = WAIT_LOW;
      WAIT_LOW: if (!pulse_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (clear) state_d = pulse_in ? WAIT_LOW : IDLE;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sym_cnt_d = sym_cnt_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      sym_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  always_ff @(posedge hwclk) begin
    if (push) mem_q[wr_ptr_q] <= read_out;
  end

  assign spi_confirm_out = (state_q == CONFIRM);
  assign nextChar        = (state_q == IDLE) && !full && !eof_block;
  assign sym_valid       = (count_q != '0);
  assign sym_data        = sym_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count      = count_q;
  assign sym_count       = sym_cnt_q;

endmodule

// File: tb/tb_t05_char_ingress.sv
// Scoreboard bench for t05_char_ingress: expected symbols queued at drive time, checked at pop.
module tb_t05_char_ingress;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              hwclk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              pulse_in = 1'b0;
  logic [DATA_W-1:0] read_out = '0;
  logic              sym_ready = 1'b0;
  logic              spi_confirm_out, nextChar, sym_valid, sym_last, eof_seen;
  logic [DATA_W-1:0] sym_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]       sym_count;

  int n_tests = 0;
  int n_fail  = 0;
  int conf_cnt = 0;
  logic prev_conf = 1'b0;
  logic [7:0] exp_q[$];

  t05_char_ingress #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EOF_CHAR(8'h1A)) dut (
    .hwclk(hwclk), .reset(reset), .clear(clear), .pulse_in(pulse_in), .read_out(read_out),
    .spi_confirm_out(spi_confirm_out), .nextChar(nextChar), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready), .eof_seen(eof_seen),
    .fifo_count(fifo_count), .sym_count(sym_count)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer side: every pop must match the oldest driven symbol.
  always @(negedge hwclk) begin
    if (spi_confirm_out) begin
      conf_cnt++;
      if (prev_conf) chk("confirm_b2b", 32'(spi_confirm_out), 32'd0);
    end
    prev_conf = spi_confirm_out;
    if (!reset && !clear && sym_valid && sym_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("pop_data", 32'(sym_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge hwclk); #1; end
  endtask

  task automatic wait_next();
    int n = 0;
    while (!nextChar && n < 50) begin tick(); n++; end
    chk("nextChar_timeout", 32'(nextChar), 32'd1);
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    wait_next();
    pulse_in = 1'b1; read_out = v; exp_q.push_back(v);
    do begin tick(); n++; end while (!spi_confirm_out && n < 50);
    chk("confirm_seen", 32'(spi_confirm_out), 32'd1);
    pulse_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    sym_ready = 1'b1;
    while (fifo_count != 0 && n < 50) begin tick(); n++; end
    chk("drain_empty", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int c0;
    logic [7:0] seq [8] = '{8'd18, 8'd18, 8'd18, 8'd31, 8'd31, 8'd18, 8'd49, 8'd18};

    // Reset held for 5 cycles
    reset = 1'b1; tick(5);
    chk("rst_confirm", 32'(spi_confirm_out), 0);
    chk("rst_valid",   32'(sym_valid), 0);
    chk("rst_data",    32'(sym_data), 0);
    chk("rst_last",    32'(sym_last), 0);
    chk("rst_eof",     32'(eof_seen), 0);
    chk("rst_fcount",  32'(fifo_count), 0);
    chk("rst_scount",  32'(sym_count), 0);
    reset = 1'b0; #1;
    chk("rst_nextChar", 32'(nextChar), 1);

    // Single capture, pulse held for 10 cycles
    sym_ready = 1'b0; tick();
    c0 = conf_cnt;
    pulse_in = 1'b1; read_out = 8'd18; exp_q.push_back(8'd18);
    tick(); chk("single_confirm_now", 32'(spi_confirm_out), 1);
    chk("single_nextChar_low", 32'(nextChar), 0);
    tick(9);
    chk("single_one_confirm", 32'(conf_cnt - c0), 1);
    chk("single_valid", 32'(sym_valid), 1);
    chk("single_data",  32'(sym_data), 32'd18);
    chk("single_scount", 32'(sym_count), 1);
    chk("single_fcount", 32'(fifo_count), 1);
    pulse_in = 1'b0;
    drain();

    // Sequence with consumer always ready
    do_clear();
    chk("clr_scount", 32'(sym_count), 0);
    sym_ready = 1'b1;
    foreach (seq[i]) send(seq[i]);
    tick(3);
    chk("seq_scount", 32'(sym_count), 8);
    chk("seq_fcount", 32'(fifo_count), 0);
    chk("seq_sb_empty", 32'(exp_q.size()), 0);

    // Full FIFO, blocked 9th symbol, single pop then wrap-ordered drain
    do_clear(); sym_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'(100 + i));
    tick(2);
    chk("full_fcount", 32'(fifo_count), DEPTH);
    chk("full_nextChar", 32'(nextChar), 0);
    c0 = conf_cnt;
    pulse_in = 1'b1; read_out = 8'd200; exp_q.push_back(8'd200);
    tick(5);
    chk("full_no_confirm", 32'(conf_cnt - c0), 0);
    chk("full_fcount_hold", 32'(fifo_count), DEPTH);
    sym_ready = 1'b1; tick(); sym_ready = 1'b0;
    chk("full_after_pop_fcount", 32'(fifo_count), DEPTH - 1);
    chk("full_after_pop_confirm", 32'(spi_confirm_out), 0);
    tick();
    chk("full_late_confirm", 32'(spi_confirm_out), 1);
    chk("full_refill", 32'(fifo_count), DEPTH);
    pulse_in = 1'b0;
    drain();
    chk("full_sb_empty", 32'(exp_q.size()), 0);

    // End-of-text handling
    do_clear(); sym_ready = 1'b0;
    send(8'd49); send(8'h1A); tick(3);
    sym_ready = 1'b1; tick(); sym_ready = 1'b0;
    chk("eof_head", 32'(sym_data), 32'h1A);
`ifdef T05_INGRESS_EOF_EN
    chk("eof_last", 32'(sym_last), 1);
    chk("eof_seen", 32'(eof_seen), 1);
    chk("eof_nextChar", 32'(nextChar), 0);
`else
    chk("eof_last", 32'(sym_last), 0);
    chk("eof_seen", 32'(eof_seen), 0);
    chk("eof_nextChar", 32'(nextChar), 1);
`endif
    do_clear();
    chk("eof_clr_nextChar", 32'(nextChar), 1);
    chk("eof_clr_scount", 32'(sym_count), 0);
    chk("eof_clr_seen", 32'(eof_seen), 0);

    // Reset asserted mid-handshake
    sym_ready = 1'b0;
    send(8'd5); send(8'd6); wait_next();
    pulse_in = 1'b1; read_out = 8'd7;
    tick();
    chk("mid_in_confirm", 32'(spi_confirm_out), 1);
    chk("mid_fcount3", 32'(fifo_count), 3);
    #2 reset = 1'b1; #1;
    chk("mid_confirm", 32'(spi_confirm_out), 0);
    chk("mid_fcount", 32'(fifo_count), 0);
    chk("mid_valid", 32'(sym_valid), 0);
    exp_q.delete();
    pulse_in = 1'b0;
    tick(2); reset = 1'b0; #1;
    chk("mid_nextChar", 32'(nextChar), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
